// File: rtl/tnn_feature_quantizer.sv
// Serial feature quantizer for the TNN neuron cores: rounds/saturates raw words to Q_W bits,
// packs NUM_FEAT of them into one vector and hands it out through a two-stage valid/ready buffer.
module tnn_feature_quantizer #(
  parameter int IN_W     = 8,
  parameter int Q_W      = 3,
  parameter int NUM_FEAT = 5,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_W-1:0]           s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [NUM_FEAT*Q_W-1:0]   m_vec,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          vec_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int SH     = IN_W - Q_W;
  localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam int IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IN_W:0]      RND      = (SH > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
  localparam logic [IN_W:0]      Q_MAX    = (IN_W+1)'((1 << Q_W) - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic {ST_FILLING, ST_F_FULL} state_t;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [NUM_FEAT*Q_W-1:0]   r_fill;
  logic [NUM_FEAT*Q_W-1:0]   r_o_vec;
  logic                      r_o_valid;
  logic                      r_frame_err;
  logic [CNT_W-1:0]          r_vec_cnt;
  logic [CNT_W-1:0]          r_err_cnt;

  logic [IN_W:0]             w_sum, w_shr;
  logic [Q_W-1:0]            w_q;
  logic [NUM_FEAT*Q_W-1:0]   w_vec_new;
  logic                      w_accept, w_last_pos, w_complete, w_err, w_o_take, w_o_free;

  // Sum is one bit wider than the input so the rounding carry of 0xFF-like words survives.
  assign w_sum = {1'b0, s_data} + RND;
  assign w_shr = w_sum >> SH;
  assign w_q   = (w_shr > Q_MAX) ? Q_MAX[Q_W-1:0] : w_shr[Q_W-1:0];

  assign s_ready    = !rst && (r_state == ST_FILLING);
  assign w_accept   = s_valid && s_ready;
  assign w_last_pos = (r_idx == LAST_IDX);
  assign w_complete = w_accept && w_last_pos && s_last;
  assign w_err      = w_accept && (s_last != w_last_pos);
  assign w_o_take   = r_o_valid && m_ready;
  assign w_o_free   = !r_o_valid || m_ready;

  always_comb begin
    // NOTE: default first so every path assigns the whole vector and no latch is inferred.
    w_vec_new = r_fill;
    w_vec_new[r_idx*Q_W +: Q_W] = w_q;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILLING: if (w_complete && !w_o_free) w_state_nxt = ST_F_FULL;
      ST_F_FULL:  if (m_ready)                 w_state_nxt = ST_FILLING;
      default:                                 w_state_nxt = ST_FILLING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILLING;
    // NOTE: non-blocking for all clocked state so every register samples pre-edge values.
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      // NOTE: the fill buffer is a handful of flops, so it is cleared with the rest rather than left unreset.
      r_fill      <= '0;
      r_o_vec     <= '0;
      r_o_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_o_take && r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + 1'b1;

      if (w_accept) begin
        if (w_err || w_complete) r_idx <= '0;
        else                     r_idx <= r_idx + 1'b1;
      end

      // Partial beats and a completed vector that cannot enter O both land in F.
      if (w_accept && !w_err && (!w_complete || !w_o_free)) r_fill <= w_vec_new;

      if (w_complete && w_o_free) begin
        r_o_vec   <= w_vec_new;
        r_o_valid <= 1'b1;
      end else if (r_state == ST_F_FULL && m_ready) begin
        r_o_vec   <= r_fill;
        r_o_valid <= 1'b1;
      end else if (w_o_take) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_o_valid;
  assign m_vec     = r_o_vec;
  assign frame_err = r_frame_err;
  assign vec_cnt   = r_vec_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tnn_feature_quantizer.sv
// Directed bench for tnn_feature_quantizer: quantize sweep, full-rate streaming,
// backpressure, framing errors and reset with content in flight.
module tb_tnn_feature_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [14:0] m_vec;
  logic        frame_err;
  logic [15:0] vec_cnt;
  logic [15:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];

  // Raw words for each vector, feature 0 in the low byte.
  localparam logic [39:0] V1 = 40'hF0_EF_10_0F_00;  // 0,0,1,7,7
  localparam logic [39:0] V2 = 40'h00_F0_EF_10_0F;  // 0,1,7,7,0
  localparam logic [39:0] V3 = 40'h1F_20_40_7F_80;  // 4,4,2,1,1
  localparam logic [39:0] V4 = 40'hE0_D0_90_50_30;  // 2,3,5,7,7
  localparam logic [39:0] V5 = 40'hFF_FF_FF_FF_FF;  // 7 x5
  localparam logic [14:0] Q1 = 15'h7E40;
  localparam logic [14:0] Q2 = 15'h0FC8;
  localparam logic [14:0] Q3 = 15'h12A4;
  localparam logic [14:0] Q4 = 15'h7F5A;
  localparam logic [14:0] Q5 = 15'h7FFF;

  tnn_feature_quantizer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_vec     (m_vec),
    .frame_err (frame_err),
    .vec_cnt   (vec_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so negedge values are those seen at the next edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back(m_vec);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("beat_timeout", n, 0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input logic [39:0] ds, input logic [4:0] lasts, input int nb);
    for (int i = 0; i < nb; i++) beat(ds[i*8 +: 8], lasts[i]);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check(tag, {17'd0, got_q[i]}, {17'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #2;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_vec", m_vec, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_s_ready", s_ready, 1);

    // Quantize sweep, back-to-back at full rate
    for (int i = 0; i < 4; i++) beat(V1[i*8 +: 8], 1'b0);
    check("lat_before_last", m_valid, 0);
    beat(V1[39:32], 1'b1);
    check("lat_m_valid", m_valid, 1);
    check("lat_m_vec", m_vec, Q1);
    send(V2, 5'b10000, 5);
    send(V3, 5'b10000, 5);
    send(V4, 5'b10000, 5);
    send(V5, 5'b10000, 5);
    check("sweep_last_vec", m_vec, Q5);
    tick(); tick();
    exp_q = '{Q1, Q2, Q3, Q4, Q5};
    drain_check("sweep");
    check("sweep_vec_cnt", vec_cnt, 5);

    // Backpressure: second vector parks in F
    m_ready = 1'b0;
    send(V3, 5'b10000, 5);
    send(V4, 5'b10000, 5);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    tick(); tick();
    check("bp_m_vec_stable", m_vec, Q3);
    check("bp_still_blocked", s_ready, 0);
    m_ready = 1'b1;
    check("bp_no_comb_path", s_ready, 0);
    tick();
    check("bp_f_to_o_vec", m_vec, Q4);
    check("bp_f_to_o_valid", m_valid, 1);
    check("bp_s_ready_back", s_ready, 1);
    tick();
    check("bp_drained", m_valid, 0);
    exp_q = '{Q3, Q4};
    drain_check("bp_order");
    check("bp_vec_cnt", vec_cnt, 7);

    // Early s_last at feature 2
    send(V3, 5'b00100, 3);
    check("early_frame_err", frame_err, 1);
    check("early_no_valid", m_valid, 0);
    tick();
    check("early_pulse_end", frame_err, 0);
    check("early_err_cnt", err_cnt, 1);
    check("early_nothing_out", got_q.size(), 0);
    send(V1, 5'b10000, 5);
    tick(); tick();
    exp_q = '{Q1};
    drain_check("early_next");

    // Missing s_last on feature 4
    send(V4, 5'b00000, 5);
    check("miss_frame_err", frame_err, 1);
    check("miss_no_valid", m_valid, 0);
    check("miss_err_cnt", err_cnt, 2);
    send(V2, 5'b10000, 5);
    tick(); tick();
    exp_q = '{Q2};
    drain_check("miss_next");
    check("miss_vec_cnt", vec_cnt, 9);

    // Reset with O full and F half-filled
    m_ready = 1'b0;
    send(V3, 5'b10000, 5);
    send(V4, 5'b00000, 2);
    check("prerst_m_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_s_ready", s_ready, 0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    check("rst_mid_vec_cnt", vec_cnt, 0);
    check("rst_mid_err_cnt", err_cnt, 0);
    tick(); tick(); tick();
    check("rst_no_stale", m_valid, 0);
    check("rst_no_stale_out", got_q.size(), 0);
    send(V5, 5'b10000, 5);
    tick(); tick();
    exp_q = '{Q5};
    drain_check("rst_after");
    check("rst_after_vec_cnt", vec_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
